line_fill_buffer: RTL and testbench
===================================

# line_fill_buffer

Fetches one 8-word (256-bit) cache line from the word-wide memory bus on a data-cache miss, critical word first with wrap-around. It assembles the line in place and hands it to the data cache. It sits directly between the data cache's miss-handling control and the memory interface. It pulses a first-word indication so the cache can release the CPU early, then a completion pulse when the whole line is valid.

## Interface
Parameters
- CRITICAL_FIRST, 1, 1: start at the missed word and wrap; 0: always start at word 0.

Ports
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Enable  in  1  fill request from cache control; sampled only in IDLE.
- MissAddr  in  32  word address of the miss; bits [2:0] select the word in the line.
- LineData  out  256  assembled line; word i occupies bits [32i+31:32i].
- LineAddr  out  32  {MissAddr[31:3],3'b000} of the current or last fill.
- FirstWord  out  1  one-cycle pulse: critical word captured.
- FirstWordData  out  32  critical word; valid while FirstWord is high and held until the next fill.
- Completed  out  1  one-cycle pulse: all 8 words captured and LineData valid.
- Busy  out  1  high in FILL and DONE.
- MemReq  out  1  word read request.
- MemAddr  out  32  word address of the outstanding request.
- MemRData  in  32  read data; valid when MemReq && MemAck.
- MemAck  in  1  memory accepts and returns the word this cycle.

## Operation
- FSM states are IDLE, FILL and DONE.
- IDLE:
  - On Enable=1, latch LineAddr and set StartIdx = CRITICAL_FIRST ? MissAddr[2:0] : 0.
  - Set Idx = StartIdx and Count = 0, then go to FILL.
  - Enable=0 keeps the block in IDLE.
- FILL:
  - MemReq=1 and MemAddr = {LineAddr[31:3], Idx}.
  - On MemReq && MemAck: write MemRData into word Idx of LineData. Idx increments mod 8 (3-bit wrap: 7 goes to 0). Count increments.
  - If Count==0 at capture, also load FirstWordData and assert FirstWord next cycle.
  - If Count==7 at capture, go to DONE.
  - MemAck=0 holds MemAddr and MemReq stable; there is no timeout.
- DONE: Completed=1 for exactly one cycle, MemReq=0, then IDLE.
- Enable during FILL or DONE is ignored and not queued. Cache control must re-assert Enable after Completed.
- MemAck while MemReq=0 is ignored.
- LineData, LineAddr and FirstWordData hold their values after Completed until the next fill overwrites them. Words not yet fetched in an active fill keep stale contents.
- Reset mid-fill aborts: state returns to IDLE, MemReq drops in the next cycle, and partial data is discarded (registers cleared).

## Timing
- Reset values are 0 for all outputs: LineData, LineAddr, FirstWordData, FirstWord, Completed, Busy, MemReq, MemAddr.
- Enable sampled at edge E:
  - MemReq and Busy are high from the cycle after E.
  - MemAddr equals the critical word address in that first cycle.
- Back-to-back acks (one per cycle) give 8 consecutive request cycles:
  - FirstWord is high in cycle E+2.
  - Completed is high in cycle E+9.
  - Back to IDLE at E+10; a new Enable is accepted in cycle E+10 or later.
- Each ack-free cycle adds one cycle to every later event.
- FirstWord and Completed are registered pulses, never combinational from MemAck.
- If the last ack is also the first (impossible with 8 words), n/a. FirstWord and Completed are never high in the same cycle.

## Test plan
- Reset: hold Rst 2 cycles, then check every output is 0 and MemReq stays 0 with Enable=0.
- Critical-first wrap:
  - Stimulus: MissAddr=0x0000_0105, MemAck=1 every cycle, MemRData = MemAddr ^ 0xA5A5_0000.
  - Required MemAddr sequence: 0x105, 0x106, 0x107, 0x100, 0x101, 0x102, 0x103, 0x104.
  - FirstWordData = 0xA5A5_0105 in cycle E+2.
  - Completed in E+9, LineAddr=0x100, LineData word i = 0xA5A5_0100+i.
- Stalled memory:
  - Stimulus: MissAddr=0x0000_2000, MemAck high only on alternate cycles.
  - Required: MemAddr is held during non-ack cycles and Completed arrives at E+17.
  - Enable pulsed mid-fill causes no extra fill.
- Reset mid-fill: assert Rst after 3 words are captured → IDLE, MemReq=0 after the reset edge, and LineData=0.
- Back-to-back fills:
  - Stimulus: Enable held high continuously, with MissAddr changed to 0x0000_3003 after the first Completed.
  - Required: the second fill starts in E+10 at address 0x3003, and the first line is preserved until its words are overwritten.
- CRITICAL_FIRST=0: MissAddr=0x0000_0107 → first MemAddr=0x100, and FirstWordData = word at 0x100.

Source files
------------

// File: rtl/line_fill_buffer_if.sv
// Word-wide memory read bus between the line fill buffer and memory.
// Master issues MemReq/MemAddr; slave answers with MemAck/MemRData.
interface line_fill_buffer_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRData;
  logic        MemAck;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemRData,
    input  MemAck
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemRData,
    output MemAck
  );
endinterface

// File: rtl/line_fill_buffer.sv
// Fills one 8-word cache line from the memory bus, critical word first.
// Ports: Clk/Rst, Enable/MissAddr in; LineData/LineAddr/FirstWord/FirstWordData/Completed/Busy out; mem bus.
module line_fill_buffer #(
  parameter int CRITICAL_FIRST = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Enable,
  input  logic [31:0]          MissAddr,
  output logic [255:0]         LineData,
  output logic [31:0]          LineAddr,
  output logic                 FirstWord,
  output logic [31:0]          FirstWordData,
  output logic                 Completed,
  output logic                 Busy,
  line_fill_buffer_if.master   mem
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] count;
  logic       start;
  logic       capture;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    capture    = 1'b0;
    mem.MemReq = 1'b0;
    Completed  = 1'b0;
    Busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Enable) begin
          start     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        Busy       = 1'b1;
        mem.MemReq = 1'b1;
        capture    = mem.MemAck;
        if (capture && count == 3'd7) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        Busy      = 1'b1;
        Completed = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem.MemAddr = {LineAddr[31:3], idx};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      LineData      <= '0;
      LineAddr      <= '0;
      FirstWord     <= 1'b0;
      FirstWordData <= '0;
      idx           <= '0;
      count         <= '0;
    end else begin
      FirstWord <= 1'b0;
      if (start) begin
        LineAddr <= {MissAddr[31:3], 3'b000};
        idx      <= (CRITICAL_FIRST != 0) ? MissAddr[2:0] : 3'd0;
        count    <= '0;
      end
      if (capture) begin
        LineData[{idx, 5'd0} +: 32] <= mem.MemRData;
        // 3-bit index wraps 7 -> 0 for critical-first order
        idx   <= idx + 3'd1;
        count <= count + 3'd1;
        if (count == 3'd0) begin
          FirstWord     <= 1'b1;
          FirstWordData <= mem.MemRData;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Self-checking bench for line_fill_buffer.
// Scoreboard of expected request addresses plus per-scenario timing checks.
module tb_line_fill_buffer;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Enable;
  logic [31:0]  MissAddr;
  logic [255:0] LineData;
  logic [31:0]  LineAddr;
  logic         FirstWord;
  logic [31:0]  FirstWordData;
  logic         Completed;
  logic         Busy;

  logic         Enable0;
  logic [31:0]  MissAddr0;
  logic [255:0] LineData0;
  logic [31:0]  LineAddr0;
  logic         FirstWord0;
  logic [31:0]  FirstWordData0;
  logic         Completed0;
  logic         Busy0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr[$];
  bit mon_en = 1'b0;

  always #5 Clk = ~Clk;

  line_fill_buffer_if mif ();
  line_fill_buffer_if mif0 ();

  assign mif.MemRData  = mif.MemAddr ^ 32'hA5A5_0000;
  assign mif0.MemRData = mif0.MemAddr ^ 32'hA5A5_0000;

  line_fill_buffer #(.CRITICAL_FIRST(1)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Enable        (Enable),
    .MissAddr      (MissAddr),
    .LineData      (LineData),
    .LineAddr      (LineAddr),
    .FirstWord     (FirstWord),
    .FirstWordData (FirstWordData),
    .Completed     (Completed),
    .Busy          (Busy),
    .mem           (mif)
  );

  line_fill_buffer #(.CRITICAL_FIRST(0)) dut0 (
    .Clk           (Clk),
    .Rst           (Rst),
    .Enable        (Enable0),
    .MissAddr      (MissAddr0),
    .LineData      (LineData0),
    .LineAddr      (LineAddr0),
    .FirstWord     (FirstWord0),
    .FirstWordData (FirstWordData0),
    .Completed     (Completed0),
    .Busy          (Busy0),
    .mem           (mif0)
  );

  function automatic logic [31:0] word_of(input logic [255:0] l, input int i);
    return l[i*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard consumer: every accepted request must match the next expected address.
  always @(negedge Clk) begin
    logic [31:0] e;
    if (mon_en && mif.MemReq && mif.MemAck) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL req_addr: got %h, no request expected", mif.MemAddr);
      end else begin
        e = exp_addr.pop_front();
        if (mif.MemAddr !== e) begin
          errors++;
          $display("FAIL req_addr: got %h want %h", mif.MemAddr, e);
        end
      end
    end
  end

  task automatic test_reset;
    Rst = 1'b1;
    Enable = 1'b0;
    MissAddr = '0;
    Enable0 = 1'b0;
    MissAddr0 = '0;
    mif.MemAck = 1'b0;
    mif0.MemAck = 1'b0;
    tick;
    tick;
    Rst = 1'b0;
    checks++;
    if ({LineData, LineAddr, FirstWordData} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h want 0", LineData, LineAddr, FirstWordData);
    end
    checks++;
    if ({FirstWord, Completed, Busy, mif.MemReq} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b%b%b%b want 0000", FirstWord, Completed, Busy, mif.MemReq);
    end
    checks++;
    if (mif.MemAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_memaddr: got %h want 0", mif.MemAddr);
    end
    checks++;
    if ({LineData0, Busy0, mif0.MemReq} !== '0) begin
      errors++;
      $display("FAIL reset_dut0: got nonzero, want 0");
    end
    for (int n = 0; n < 3; n++) begin
      tick;
      checks++;
      if (mif.MemReq !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_noreq: got req=%b busy=%b want 0 0", mif.MemReq, Busy);
      end
    end
  endtask

  task automatic test_critical_wrap;
    for (int i = 0; i < 8; i++) exp_addr.push_back(32'h100 + ((5 + i) & 7));
    mon_en = 1'b1;
    MissAddr = 32'h0000_0105;
    Enable = 1'b1;
    mif.MemAck = 1'b1;
    tick;
    Enable = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      if (n == 1) begin
        checks++;
        if (mif.MemReq !== 1'b1 || Busy !== 1'b1 || mif.MemAddr !== 32'h105) begin
          errors++;
          $display("FAIL wrap_start: got req=%b busy=%b addr=%h want 1 1 00000105",
                   mif.MemReq, Busy, mif.MemAddr);
        end
      end
      checks++;
      if (FirstWord !== (n == 2)) begin
        errors++;
        $display("FAIL wrap_firstword: cycle E+%0d got %b want %b", n, FirstWord, (n == 2));
      end
      checks++;
      if (Completed !== (n == 9)) begin
        errors++;
        $display("FAIL wrap_completed: cycle E+%0d got %b want %b", n, Completed, (n == 9));
      end
      if (n == 2) begin
        checks++;
        if (FirstWordData !== 32'hA5A5_0105) begin
          errors++;
          $display("FAIL wrap_fwdata: got %h want a5a50105", FirstWordData);
        end
      end
      if (n == 9) begin
        checks++;
        if (LineAddr !== 32'h100) begin
          errors++;
          $display("FAIL wrap_lineaddr: got %h want 00000100", LineAddr);
        end
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (word_of(LineData, i) !== 32'hA5A5_0100 + i) begin
            errors++;
            $display("FAIL wrap_word%0d: got %h want %h", i, word_of(LineData, i), 32'hA5A5_0100 + i);
          end
        end
      end
      if (n == 10) begin
        checks++;
        if (Busy !== 1'b0 || mif.MemReq !== 1'b0) begin
          errors++;
          $display("FAIL wrap_idle: got busy=%b req=%b want 0 0", Busy, mif.MemReq);
        end
      end
      tick;
    end
    mif.MemAck = 1'b0;
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL wrap_reqcount: got %0d missing requests want 0", exp_addr.size());
      exp_addr.delete();
    end
  endtask

  task automatic test_stall;
    logic [31:0] cur;
    cur = 32'h2000;
    for (int i = 0; i < 8; i++) exp_addr.push_back(32'h2000 + i);
    MissAddr = 32'h0000_2000;
    Enable = 1'b1;
    mif.MemAck = 1'b0;
    tick;
    Enable = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      mif.MemAck = (n % 2 == 0) && (n <= 16);
      Enable = (n == 5);
      MissAddr = (n == 5) ? 32'h0000_5555 : 32'h0000_2000;
      if (n <= 16) begin
        checks++;
        if (mif.MemReq !== 1'b1 || mif.MemAddr !== cur) begin
          errors++;
          $display("FAIL stall_hold: cycle E+%0d got req=%b addr=%h want 1 %h",
                   n, mif.MemReq, mif.MemAddr, cur);
        end
      end
      checks++;
      if (FirstWord !== (n == 3)) begin
        errors++;
        $display("FAIL stall_firstword: cycle E+%0d got %b want %b", n, FirstWord, (n == 3));
      end
      checks++;
      if (Completed !== (n == 17)) begin
        errors++;
        $display("FAIL stall_completed: cycle E+%0d got %b want %b", n, Completed, (n == 17));
      end
      if (n == 17) begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (word_of(LineData, i) !== 32'hA5A5_2000 + i) begin
            errors++;
            $display("FAIL stall_word%0d: got %h want %h", i, word_of(LineData, i), 32'hA5A5_2000 + i);
          end
        end
      end
      if (n >= 18) begin
        checks++;
        if (mif.MemReq !== 1'b0 || Busy !== 1'b0 || LineAddr !== 32'h2000) begin
          errors++;
          $display("FAIL stall_noextra: cycle E+%0d got req=%b busy=%b la=%h want 0 0 00002000",
                   n, mif.MemReq, Busy, LineAddr);
        end
      end
      if (mif.MemAck) cur = cur + 1;
      tick;
    end
    Enable = 1'b0;
    mif.MemAck = 1'b0;
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL stall_reqcount: got %0d missing requests want 0", exp_addr.size());
      exp_addr.delete();
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) exp_addr.push_back(32'h400 + i);
    MissAddr = 32'h0000_0400;
    Enable = 1'b1;
    mif.MemAck = 1'b1;
    tick;
    Enable = 1'b0;
    tick;
    tick;
    tick;
    mif.MemAck = 1'b0;
    checks++;
    if (mif.MemReq !== 1'b1 || word_of(LineData, 2) !== 32'hA5A5_0402) begin
      errors++;
      $display("FAIL mid_before: got req=%b w2=%h want 1 a5a50402", mif.MemReq, word_of(LineData, 2));
    end
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    checks++;
    if (mif.MemReq !== 1'b0 || Busy !== 1'b0 || FirstWord !== 1'b0 || Completed !== 1'b0) begin
      errors++;
      $display("FAIL mid_ctl: got req=%b busy=%b want 0 0", mif.MemReq, Busy);
    end
    checks++;
    if (LineData !== '0 || LineAddr !== '0 || FirstWordData !== '0 || mif.MemAddr !== '0) begin
      errors++;
      $display("FAIL mid_clear: got w0=%h la=%h want 0 0", word_of(LineData, 0), LineAddr);
    end
    tick;
    checks++;
    if (mif.MemReq !== 1'b0) begin
      errors++;
      $display("FAIL mid_stay_idle: got %b want 0", mif.MemReq);
    end
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL mid_reqcount: got %0d missing requests want 0", exp_addr.size());
      exp_addr.delete();
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) exp_addr.push_back(32'h600 + i);
    for (int i = 0; i < 8; i++) exp_addr.push_back(32'h3000 + ((3 + i) & 7));
    MissAddr = 32'h0000_0600;
    Enable = 1'b1;
    mif.MemAck = 1'b1;
    tick;
    for (int n = 1; n <= 21; n++) begin
      if (n == 9) begin
        checks++;
        if (Completed !== 1'b1) begin
          errors++;
          $display("FAIL b2b_first_done: got %b want 1", Completed);
        end
        MissAddr = 32'h0000_3003;
      end
      if (n == 10) begin
        checks++;
        if (Busy !== 1'b0 || mif.MemReq !== 1'b0 || Completed !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap: got busy=%b req=%b done=%b want 0 0 0", Busy, mif.MemReq, Completed);
        end
      end
      if (n == 11) begin
        checks++;
        if (mif.MemReq !== 1'b1 || mif.MemAddr !== 32'h3003 || LineAddr !== 32'h3000) begin
          errors++;
          $display("FAIL b2b_second_start: got req=%b addr=%h la=%h want 1 00003003 00003000",
                   mif.MemReq, mif.MemAddr, LineAddr);
        end
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (word_of(LineData, i) !== 32'hA5A5_0600 + i) begin
            errors++;
            $display("FAIL b2b_keep%0d: got %h want %h", i, word_of(LineData, i), 32'hA5A5_0600 + i);
          end
        end
      end
      if (n == 12) begin
        checks++;
        if (FirstWord !== 1'b1 || FirstWordData !== 32'hA5A5_3003) begin
          errors++;
          $display("FAIL b2b_firstword: got %b %h want 1 a5a53003", FirstWord, FirstWordData);
        end
        checks++;
        if (word_of(LineData, 3) !== 32'hA5A5_3003 || word_of(LineData, 0) !== 32'hA5A5_0600) begin
          errors++;
          $display("FAIL b2b_partial: got w3=%h w0=%h want a5a53003 a5a50600",
                   word_of(LineData, 3), word_of(LineData, 0));
        end
      end
      if (n == 19) begin
        checks++;
        if (Completed !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_done: got %b want 1", Completed);
        end
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (word_of(LineData, i) !== 32'hA5A5_3000 + i) begin
            errors++;
            $display("FAIL b2b_word%0d: got %h want %h", i, word_of(LineData, i), 32'hA5A5_3000 + i);
          end
        end
        Enable = 1'b0;
      end
      if (n >= 20) begin
        checks++;
        if (mif.MemReq !== 1'b0) begin
          errors++;
          $display("FAIL b2b_end_idle: cycle E+%0d got %b want 0", n, mif.MemReq);
        end
      end
      tick;
    end
    mif.MemAck = 1'b0;
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL b2b_reqcount: got %0d missing requests want 0", exp_addr.size());
      exp_addr.delete();
    end
  endtask

  task automatic test_no_critical;
    MissAddr0 = 32'h0000_0107;
    Enable0 = 1'b1;
    mif0.MemAck = 1'b1;
    tick;
    Enable0 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (n == 1) begin
        checks++;
        if (mif0.MemReq !== 1'b1 || mif0.MemAddr !== 32'h100) begin
          errors++;
          $display("FAIL cf0_start: got req=%b addr=%h want 1 00000100", mif0.MemReq, mif0.MemAddr);
        end
      end
      if (n == 2) begin
        checks++;
        if (FirstWord0 !== 1'b1 || FirstWordData0 !== 32'hA5A5_0100) begin
          errors++;
          $display("FAIL cf0_firstword: got %b %h want 1 a5a50100", FirstWord0, FirstWordData0);
        end
      end
      if (n == 9) begin
        checks++;
        if (Completed0 !== 1'b1 || LineAddr0 !== 32'h100) begin
          errors++;
          $display("FAIL cf0_done: got %b %h want 1 00000100", Completed0, LineAddr0);
        end
        checks++;
        if (word_of(LineData0, 7) !== 32'hA5A5_0107 || word_of(LineData0, 0) !== 32'hA5A5_0100) begin
          errors++;
          $display("FAIL cf0_words: got w7=%h w0=%h want a5a50107 a5a50100",
                   word_of(LineData0, 7), word_of(LineData0, 0));
        end
      end
      tick;
    end
    mif0.MemAck = 1'b0;
  endtask

  initial begin
    test_reset;
    test_critical_wrap;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_no_critical;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
